// File: rtl/framebuffer_write_arbiter.sv
// Round-robin arbiter sharing one single-beat Avalon-MM write master between the
// clear engine (port 0) and the rasterizer (port 1); double-buffered base, deferred swap.
//   state | meaning
//   IDLE  | apply a pending swap, or grant one requester and capture its write
//   WRITE | hold the captured write until waitrequest drops
module framebuffer_write_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic [17:0] r0_offset,
    input  logic [63:0] r0_data,
    input  logic [7:0]  r0_byteenable,
    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic [17:0] r1_offset,
    input  logic [63:0] r1_data,
    input  logic [7:0]  r1_byteenable,
    input  logic        swap,
    output logic        target_buffer,
    output logic        range_error,
    output logic [28:0] address,
    output logic [7:0]  burstcount,
    output logic [63:0] writedata,
    output logic [7:0]  byteenable,
    output logic        write,
    input  logic        waitrequest
);
    localparam logic [28:0] FRAMEBUFFER1_START = 29'h0700_0000;
    localparam logic [28:0] FRAMEBUFFER2_START = 29'h0702_5800;
    localparam logic [17:0] FRAMEBUFFER_WORDS  = 18'h25800;

    typedef enum logic {IDLE, WRITE} state_t;

    state_t      state_q, state_d;
    logic [28:0] address_q, address_d;
    logic [63:0] writedata_q, writedata_d;
    logic [7:0]  byteenable_q, byteenable_d;
    logic        write_q, write_d;
    logic        target_buffer_q, target_buffer_d;
    logic        range_error_q, range_error_d;
    logic        swap_pending_q, swap_pending_d;
    logic        last_grant_q, last_grant_d;

    logic        grant0, grant1;
    logic [17:0] sel_offset;
    logic [63:0] sel_data;
    logic [7:0]  sel_be;
    logic [28:0] base;

    // A pending swap blocks grants so the toggle lands on an idle bus.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == IDLE && !swap_pending_q) begin
            if (r0_valid && r1_valid) begin
                grant0 = last_grant_q;
                grant1 = ~last_grant_q;
            end else begin
                grant0 = r0_valid;
                grant1 = r1_valid;
            end
        end
    end

    assign sel_offset = grant1 ? r1_offset     : r0_offset;
    assign sel_data   = grant1 ? r1_data       : r0_data;
    assign sel_be     = grant1 ? r1_byteenable : r0_byteenable;
    assign base       = target_buffer_q ? FRAMEBUFFER2_START : FRAMEBUFFER1_START;

    always_comb begin
        state_d         = state_q;
        address_d       = address_q;
        writedata_d     = writedata_q;
        byteenable_d    = byteenable_q;
        write_d         = write_q;
        target_buffer_d = target_buffer_q;
        range_error_d   = range_error_q;
        swap_pending_d  = swap_pending_q | swap;
        last_grant_d    = last_grant_q;

        if (state_q == IDLE) begin
            if (swap_pending_q) begin
                // A pulse coinciding with the toggle is absorbed: one toggle per pending swap.
                target_buffer_d = ~target_buffer_q;
                swap_pending_d  = 1'b0;
            end else if (grant0 || grant1) begin
                last_grant_d = grant1;
                if (sel_offset >= FRAMEBUFFER_WORDS) begin
                    range_error_d = 1'b1;
                end else begin
                    address_d    = base + {11'b0, sel_offset};
                    writedata_d  = sel_data;
                    byteenable_d = sel_be;
                    write_d      = 1'b1;
                    state_d      = WRITE;
                end
            end
        end else begin
            if (!waitrequest) begin
                write_d = 1'b0;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            address_q       <= '0;
            writedata_q     <= '0;
            byteenable_q    <= '0;
            write_q         <= 1'b0;
            target_buffer_q <= 1'b0;
            range_error_q   <= 1'b0;
            swap_pending_q  <= 1'b0;
            last_grant_q    <= 1'b1;
        end else begin
            state_q         <= state_d;
            address_q       <= address_d;
            writedata_q     <= writedata_d;
            byteenable_q    <= byteenable_d;
            write_q         <= write_d;
            target_buffer_q <= target_buffer_d;
            range_error_q   <= range_error_d;
            swap_pending_q  <= swap_pending_d;
            last_grant_q    <= last_grant_d;
        end
    end

    assign r0_ready      = grant0;
    assign r1_ready      = grant1;
    assign target_buffer = target_buffer_q;
    assign range_error   = range_error_q;
    assign address       = address_q;
    assign burstcount    = 8'h01;
    assign writedata     = writedata_q;
    assign byteenable    = byteenable_q;
    assign write         = write_q;
endmodule

// File: doc/framebuffer_write_arbiter.md
# framebuffer_write_arbiter

Shares the single DDR3 Avalon-MM write master between two pixel-write requesters: the framebuffer clear engine (port 0) and the rasterizer (port 1). Requesters present word offsets within a framebuffer. The arbiter adds the base of the currently targeted buffer (double-buffered: FRAMEBUFFER1/FRAMEBUFFER2). It sequences one single-beat write at a time, uses round-robin arbitration, and defers buffer swaps until the bus is idle.

## Interface
- FRAMEBUFFER1_START, 29'h0700_0000, word address of buffer 0
- FRAMEBUFFER2_START, 29'h0702_5800, word address of buffer 1
- FRAMEBUFFER_WORDS, 18'h25800, words per buffer; valid offsets 0..FRAMEBUFFER_WORDS-1
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- r0_valid / r1_valid  in  1  requester has a write pending
- r0_ready / r1_ready  out  1  request consumed this cycle (combinational from state + valid)
- r0_offset / r1_offset  in  18  word offset within target buffer
- r0_data / r1_data  in  64  write data
- r0_byteenable / r1_byteenable  in  8  byte lanes
- swap  in  1  one-cycle pulse: toggle target buffer
- target_buffer  out  1  0 = FRAMEBUFFER1, 1 = FRAMEBUFFER2
- range_error  out  1  sticky: an out-of-range offset was consumed
- address  out  29  Avalon word address
- burstcount  out  8  constant 8'h01
- writedata  out  64  Avalon write data
- byteenable  out  8  Avalon byte enables
- write  out  1  Avalon write request
- waitrequest  in  1  Avalon stall

## Operation
- Reset values: state IDLE, write 0, address 0, writedata 0, byteenable 0, r*_ready 0, target_buffer 0, range_error 0, swap_pending 0, last_grant 1 (port 0 wins the first tie).
- swap pulse sets swap_pending. A swap arriving while swap_pending is already set has no additional effect (no double toggle).
- IDLE, swap_pending=1: toggle target_buffer, clear swap_pending, grant nobody this cycle. The swap takes priority over pending requests.
- IDLE, swap_pending=0, grant selection:
  - Only one port valid: that port is granted.
  - Both ports valid: the port != last_grant is granted.
- On grant:
  - rN_ready=1 for that cycle; last_grant <= N.
  - Offset in range: address <= base(target_buffer) + zero-extended offset; writedata and byteenable are captured; write <= 1; go to WRITE.
  - Offset >= FRAMEBUFFER_WORDS: request consumed, no bus write, range_error <= 1, stay in IDLE.
- WRITE: address, writedata, byteenable and write are held stable while waitrequest=1. At the edge where waitrequest=0: write <= 0, go to IDLE. r*_ready=0 throughout WRITE.
- swap during WRITE only sets swap_pending. It is applied in the first IDLE cycle, so writes already captured complete to the old buffer.
- Address arithmetic is 29-bit with no wrap. Range checking guarantees that base+offset stays inside the buffer.

## Timing
- Accept-to-write latency: write asserts the cycle after rN_ready.
- Minimum two cycles per write: one IDLE grant cycle, then one WRITE cycle with waitrequest=0. Peak rate is one write every two cycles.
- rN_ready is never asserted without the matching rN_valid. At most one ready is high per cycle.
- A requester must hold valid, offset, data and byteenable stable until ready is seen. Requesters may deassert valid before being granted.
- Round-robin guarantees no starvation: with both ports continuously valid, grants alternate 0,1,0,1.
- Reset during WRITE: write drops asynchronously to 0. The transaction is abandoned and not retried.

## Test plan
- Single write: r0_valid, offset 18'h00010, data 64'hDEADBEEFCAFEBABE, be 8'hFF, waitrequest=0 → r0_ready for 1 cycle, next cycle write=1, address 29'h0700_0010, then write=0.
- Stall: same request with waitrequest held high 5 cycles → address/data/write stable for 6 cycles, single completion, no second ready.
- Contention: both ports valid continuously, 8 requests each → grants alternate 0,1,0,1…, starting with port 0; every write lands at its own port's offset.
- Swap deferral: swap pulse during a stalled write at offset 0 → write completes at 29'h0700_0000; next IDLE cycle target_buffer=1 with no grant; the next r1 request at offset 0 writes 29'h0702_5800. Two swap pulses during one stall → exactly one toggle.
- Range error: r1 offset 18'h25800 → r1_ready pulses, write never asserts, range_error=1 and stays set; a following valid request still writes normally.
- Reset mid-write: assert reset with write=1 and waitrequest=1 → write=0 immediately; after release target_buffer=0, range_error=0, and port 0 wins the first tie.
